// File: rtl/cnt_pwm_pkg.sv
// Shared types and helpers for the counter-driven PWM generator: FSM state
// encoding, default widths and duty saturation.
package cnt_pwm_pkg;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_PERIOD_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Clamp a requested high time to one full period (2^width clocks).
  function automatic logic [31:0] sat_duty(input logic [31:0] duty,
                                           input int unsigned width);
    logic [31:0] max_duty;
    max_duty = 32'd1 << width;
    return (duty > max_duty) ? max_duty : duty;
  endfunction

endpackage

// File: rtl/cnt_wrap_det.sv
// Samples the upstream counter once per clock and flags the all-ones -> zero
// wrap plus any step that is not a +1 increment.
module cnt_wrap_det
  import cnt_pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             wrap_det_o,
  output logic             seq_bad_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign cnt_d = cnt_i;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_det_o = (cnt_q == '1) && (cnt_i == '0);
  // Sum is WIDTH bits wide, so the all-ones -> zero step counts as in sequence.
  assign seq_bad_o  = (cnt_i != (cnt_q + 1'b1));

endmodule

// File: rtl/cnt_pwm_gen.sv
// PWM from an external free-running counter with period-aligned duty updates;
// output registered (1 clk after cnt). Macro CNT_PWM_SEQ_CHECK_EN adds a sticky count-sequence error.
module cnt_pwm_gen
  import cnt_pwm_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int PERIOD_CNT_W = DEF_PERIOD_CNT_W
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        cnt,
  input  logic [WIDTH:0]          duty_in,
  input  logic                    duty_valid,
  output logic                    duty_ready,
  output logic                    pwm_out,
  output logic                    wrap,
  output logic [PERIOD_CNT_W-1:0] period_count,
  output logic                    err
);

  state_e                  state_q, state_d;
  logic                    pwm_q, pwm_d;
  logic                    wrap_q, wrap_d;
  logic [PERIOD_CNT_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH:0]          active_q, active_d;
  logic [WIDTH:0]          shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  logic                    wrap_det;
  logic                    seq_bad;
  logic                    xfer;
  logic [WIDTH:0]          duty_sat;
  logic [WIDTH:0]          eff;
  logic                    cmp_hi;

  cnt_wrap_det #(
    .WIDTH(WIDTH)
  ) u_wrap_det (
    .clk       (clk),
    .clr       (clr),
    .cnt_i     (cnt),
    .wrap_det_o(wrap_det),
    .seq_bad_o (seq_bad)
  );

  assign duty_ready = ~pending_q;
  assign xfer       = duty_valid && duty_ready;
  assign duty_sat   = (WIDTH+1)'(sat_duty(32'(duty_in), WIDTH));
  assign eff        = (wrap_det && pending_q) ? shadow_q : active_q;
  assign cmp_hi     = ({1'b0, cnt} < eff);

`ifdef CNT_PWM_SEQ_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  logic seq_bad_unused;
  assign seq_bad_unused = seq_bad;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pwm_d     = 1'b0;
    wrap_d    = 1'b0;
    pcnt_d    = pcnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
`ifdef CNT_PWM_SEQ_CHECK_EN
    err_d     = err_q;
`endif

    if (wrap_det) begin
      active_d  = eff;
      pending_d = 1'b0;
    end

    // A transfer on the wrap edge lands in the shadow; the old shadow applies now.
    if (xfer) begin
      shadow_d = duty_sat;
      if (state_q == ST_IDLE) begin
        active_d = duty_sat;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ARMED;
          pcnt_d  = '0;
        end
      end
      ST_ARMED: begin
        if (cnt == '0) begin
          state_d = ST_RUN;
          pwm_d   = cmp_hi;
        end
      end
      ST_RUN: begin
        pwm_d  = cmp_hi;
        wrap_d = wrap_det;
        if (wrap_det) begin
          pcnt_d = pcnt_q + 1'b1;
        end
`ifdef CNT_PWM_SEQ_CHECK_EN
        if (seq_bad) begin
          state_d = ST_ARMED;
          pwm_d   = 1'b0;
          wrap_d  = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable parks the block; a pending duty is promoted so re-arming uses it.
    if (!enable && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pwm_d   = 1'b0;
      wrap_d  = 1'b0;
`ifdef CNT_PWM_SEQ_CHECK_EN
      err_d   = 1'b0;
`endif
      if (pending_d) begin
        active_d  = shadow_d;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      pwm_q     <= 1'b0;
      wrap_q    <= 1'b0;
      pcnt_q    <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= pwm_d;
      wrap_q    <= wrap_d;
      pcnt_q    <= pcnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

`ifdef CNT_PWM_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign pwm_out      = pwm_q;
  assign wrap         = wrap_q;
  assign period_count = pcnt_q;

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Directed bench for cnt_pwm_gen: the bench drives the counter value itself and
// checks PWM, wrap, period count, handshake and error against hand-derived values.
module tb_cnt_pwm_gen;

`ifdef CNT_PWM_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic [3:0] cnt;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap;
  logic [7:0] period_count;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  cnt_pwm_gen #(
    .WIDTH       (4),
    .PERIOD_CNT_W(8)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .enable      (enable),
    .cnt         (cnt),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .wrap        (wrap),
    .period_count(period_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-clock counter period; duty d in force for the whole period.
  // w0: wrap expected after the cnt=0 edge; pc: period_count after that edge;
  // a duty value sv is offered at index sk (sk<0: none).
  task automatic period(input int d, input bit w0, input int pc, input int sv, input int sk);
    for (int k = 0; k < 16; k++) begin
      cnt        = 4'(k);
      duty_in    = 5'(sv);
      duty_valid = (k == sk);
      tick();
      duty_valid = 1'b0;
      chk("pwm", 32'(pwm_out), 32'(k < d));
      chk("wrap", 32'(wrap), 32'((k == 0) && w0));
      chk("pcnt", 32'(period_count), 32'(pc));
      chk("rdy", 32'(duty_ready), 32'(!(sk >= 0 && k >= sk)));
    end
  endtask

  initial begin
    clr        = 1'b0;
    enable     = 1'b0;
    cnt        = 4'd0;
    duty_in    = 5'd0;
    duty_valid = 1'b0;

    // 1. Asynchronous reset asserted between clock edges.
    #2 clr = 1'b1;
    #1;
    chk("rst_async_pwm", 32'(pwm_out), 32'd0);
    chk("rst_async_wrap", 32'(wrap), 32'd0);
    chk("rst_async_rdy", 32'(duty_ready), 32'd1);
    chk("rst_async_pcnt", 32'(period_count), 32'd0);
    chk("rst_async_err", 32'(err), 32'd0);
    tick();
    tick();
    clr = 1'b0;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_rdy", 32'(duty_ready), 32'd1);
    chk("rst_pcnt", 32'(period_count), 32'd0);

    // 2. Load 5 in IDLE, arm at cnt=11, run three periods.
    cnt = 4'd10; duty_in = 5'd5; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    chk("idle_load_rdy", 32'(duty_ready), 32'd1);
    chk("idle_pwm", 32'(pwm_out), 32'd0);
    cnt = 4'd11; enable = 1'b1;
    tick();
    chk("arm_pcnt", 32'(period_count), 32'd0);
    for (int k = 12; k < 16; k++) begin
      cnt = 4'(k);
      tick();
      chk("armed_pwm", 32'(pwm_out), 32'd0);
      chk("armed_wrap", 32'(wrap), 32'd0);
    end
    period(5, 1'b0, 0, 0, -1);
    period(5, 1'b1, 1, 0, -1);
    period(5, 1'b1, 2, 0, -1);

    // 3. Offer 12 at cnt=7: current period stays 5, next is 12.
    period(5, 1'b1, 3, 12, 7);
    // 4. Boundaries: 0, full period 16, oversize 20 saturating.
    period(12, 1'b1, 4, 0, 2);
    period(0, 1'b1, 5, 0, -1);
    period(0, 1'b1, 6, 0, -1);
    period(0, 1'b1, 7, 16, 5);
    period(16, 1'b1, 8, 20, 9);
    period(16, 1'b1, 9, 5, 4);
    period(5, 1'b1, 10, 0, -1);

    // 5. Pending 9 offered at cnt=1, disable at cnt=3, re-enable at cnt=9.
    for (int k = 0; k < 3; k++) begin
      cnt = 4'(k); duty_in = 5'd9; duty_valid = (k == 1);
      tick();
      duty_valid = 1'b0;
      chk("dis_pre_pwm", 32'(pwm_out), 32'(k < 5));
      chk("dis_pre_rdy", 32'(duty_ready), 32'(k < 1));
    end
    cnt = 4'd3; enable = 1'b0;
    tick();
    chk("dis_pwm", 32'(pwm_out), 32'd0);
    chk("dis_rdy", 32'(duty_ready), 32'd1);
    chk("dis_pcnt_kept", 32'(period_count), 32'd11);
    for (int k = 4; k < 16; k++) begin
      cnt = 4'(k);
      enable = (k >= 9);
      tick();
      chk("rearm_pwm", 32'(pwm_out), 32'd0);
      chk("rearm_wrap", 32'(wrap), 32'd0);
      if (k >= 9) chk("rearm_pcnt", 32'(period_count), 32'd0);
    end
    period(9, 1'b0, 0, 0, -1);
    period(9, 1'b1, 1, 0, -1);

    // 6. Counter jumps 6 -> 15.
    for (int k = 0; k < 7; k++) begin
      cnt = 4'(k);
      tick();
      chk("jmp_pre_pwm", 32'(pwm_out), 32'(k < 9));
      chk("jmp_pre_wrap", 32'(wrap), 32'(k == 0));
      chk("jmp_pre_pcnt", 32'(period_count), 32'd2);
    end
    cnt = 4'd15;
    tick();
    chk("jmp_pwm", 32'(pwm_out), 32'd0);
    chk("jmp_err", 32'(err), 32'(SEQ));
    chk("jmp_wrap", 32'(wrap), 32'd0);
    cnt = 4'd0;
    tick();
    chk("jmp0_pwm", 32'(pwm_out), 32'd1);
    chk("jmp0_wrap", 32'(wrap), 32'(!SEQ));
    chk("jmp0_pcnt", 32'(period_count), SEQ ? 32'd2 : 32'd3);
    for (int k = 1; k < 16; k++) begin
      cnt = 4'(k);
      tick();
      chk("jmp_post_pwm", 32'(pwm_out), 32'(k < 9));
      chk("jmp_post_err", 32'(err), 32'(SEQ));
    end
    period(9, 1'b1, SEQ ? 3 : 4, 0, -1);

    // Stalled counter held at 3 for four clocks.
    for (int k = 0; k < 4; k++) begin
      cnt = 4'(k);
      tick();
      chk("stall_pre_pwm", 32'(pwm_out), 32'(k < 9));
      chk("stall_pre_pcnt", 32'(period_count), SEQ ? 32'd4 : 32'd5);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pwm", 32'(pwm_out), 32'(!SEQ));
      chk("stall_wrap", 32'(wrap), 32'd0);
    end
    for (int k = 4; k < 16; k++) begin
      cnt = 4'(k);
      tick();
      chk("stall_post_pwm", 32'(pwm_out), 32'(!SEQ && (k < 9)));
    end
    period(9, !SEQ, SEQ ? 4 : 6, 0, -1);

    // clr mid-RUN while pwm_out is high.
    for (int k = 0; k < 3; k++) begin
      cnt = 4'(k);
      tick();
      chk("clr_pre_pwm", 32'(pwm_out), 32'd1);
    end
    #3 clr = 1'b1;
    #1;
    chk("clr_pwm", 32'(pwm_out), 32'd0);
    chk("clr_wrap", 32'(wrap), 32'd0);
    chk("clr_rdy", 32'(duty_ready), 32'd1);
    chk("clr_pcnt", 32'(period_count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    cnt = 4'd3;
    tick();
    cnt = 4'd4;
    tick();
    chk("clr_hold_pwm", 32'(pwm_out), 32'd0);
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
